// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : round-robin arbiter/sequencer for the shared 4:1 memory
//                    port mux, with ack wait and timeout abort.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mem_ack,
  output logic [1:0] mux_sel,
  output logic [3:0] grant,
  output logic       mem_req,
  output logic [3:0] done,
  output logic [3:0] err,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int                   TO_LAST_I = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_WIDTH-1:0] TO_LAST = TO_LAST_I[CNT_WIDTH-1:0];

  logic [0:0]           state_q, state_d;
  logic [3:0]           grant_q, grant_d;
  logic [1:0]           mux_sel_q, mux_sel_d;
  logic                 mem_req_q, mem_req_d;
  logic [3:0]           done_q, done_d;
  logic [3:0]           err_q, err_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           last_grant_q, last_grant_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] scan_idx;
  logic       ack_fire;
  logic       to_fire;

  // Rotating-priority scan starting just after the previous winner.
  always_comb begin
    found    = 1'b0;
    winner   = 2'd0;
    scan_idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_grant_q + 2'(k);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 4'd0;
      mux_sel_q    <= 2'd0;
      mem_req_q    <= 1'b0;
      done_q       <= 4'd0;
      err_q        <= 4'd0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= 2'd3;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      mux_sel_q    <= mux_sel_d;
      mem_req_q    <= mem_req_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state; mem_ack takes precedence over a coincident timeout.
  always_comb begin
    state_d  = state_q;
    ack_fire = 1'b0;
    to_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (mem_ack)                        ack_fire = 1'b1;
        else if (TO_EN && cnt_q == TO_LAST) to_fire  = 1'b1;
        if (ack_fire || to_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    mux_sel_d    = mux_sel_q;
    mem_req_d    = mem_req_q;
    done_d       = 4'd0;
    err_d        = 4'd0;
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d   = 4'b0001 << winner;
          mux_sel_d = winner;
          mem_req_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
        end
      end
      ST_BUSY: begin
        if (ack_fire || to_fire) begin
          done_d       = ack_fire ? (4'b0001 << mux_sel_q) : 4'd0;
          err_d        = to_fire  ? (4'b0001 << mux_sel_q) : 4'd0;
          grant_d      = 4'd0;
          mem_req_d    = 1'b0;
          busy_d       = 1'b0;
          last_grant_d = mux_sel_q;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  assign grant   = grant_q;
  assign mux_sel = mux_sel_q;
  assign mem_req = mem_req_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed + randomized bench for mem_port_arbiter
//                       against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       mem_ack;
  logic [1:0] mux_sel;
  logic [3:0] grant;
  logic       mem_req;
  logic [3:0] done;
  logic [3:0] err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mem_ack (mem_ack),
    .mux_sel (mux_sel),
    .grant   (grant),
    .mem_req (mem_req),
    .done    (done),
    .err     (err),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one outstanding transaction with an owner and an age.
  bit         m_busy;
  int         m_owner;
  int         m_last;
  int         m_age;
  logic [3:0] e_done;
  logic [3:0] e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model(input logic [3:0] r, input logic a, input logic rs);
    int w;
    e_done = 4'd0;
    e_err  = 4'd0;
    if (rs) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_last  = 3;
      m_age   = 0;
    end else if (!m_busy) begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_age   = 0;
      end
    end else if (a) begin
      e_done = 4'(1 << m_owner);
      m_busy = 1'b0;
      m_last = m_owner;
    end else if (m_age == TO - 1) begin
      e_err  = 4'(1 << m_owner);
      m_busy = 1'b0;
      m_last = m_owner;
    end else begin
      m_age++;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic a, input logic rs);
    @(negedge clk);
    req     = r;
    mem_ack = a;
    rst     = rs;
    @(posedge clk);
    model(r, a, rs);
    #1;
    chk("grant",   32'(grant),   m_busy ? 32'(1 << m_owner) : 32'd0);
    chk("mux_sel", 32'(mux_sel), 32'(m_owner));
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    chk("busy",    32'(busy),    32'(m_busy));
    chk("done",    32'(done),    32'(e_done));
    chk("err",     32'(err),     32'(e_err));
    chk("done_err_excl", 32'(done & err), 32'd0);
  endtask

  int         order[$];
  int         mreq_cnt;
  logic [3:0] err_seen;
  logic [3:0] done_seen;
  logic [3:0] prev_grant;
  int         exp_order[5];

  initial begin
    req = 4'd0; mem_ack = 1'b0; rst = 1'b1;
    m_busy = 0; m_owner = 0; m_last = 3; m_age = 0;
    e_done = 0; e_err = 0;

    // Reset, then a single requester with ack in its third busy cycle.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("rst_grant", 32'(grant), 32'd0);
    step(4'b0100, 1'b0, 1'b0);
    chk("t1_grant", 32'(grant), 32'h4);
    chk("t1_sel",   32'(mux_sel), 32'd2);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    chk("t1_done", 32'(done), 32'h4);
    step(4'b0000, 1'b0, 1'b0);
    chk("t1_idle", 32'(busy), 32'd0);

    // All four requesting, ack one cycle after each mem_req.
    step(4'b0000, 1'b0, 1'b1);
    prev_grant = 4'd0;
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, m_busy, 1'b0);
      if (grant != 4'd0 && prev_grant == 4'd0) order.push_back(int'(mux_sel));
      prev_grant = grant;
    end
    exp_order = '{0, 1, 2, 3, 0};
    chk("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(exp_order[i]));

    // Timeout with no ack.
    step(4'b0000, 1'b0, 1'b1);
    mreq_cnt = 0; err_seen = 4'd0; done_seen = 4'd0;
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 1'b0, 1'b0);
      if (mem_req) mreq_cnt++;
      err_seen  |= err;
      done_seen |= done;
    end
    chk("to_mreq_cycles", 32'(mreq_cnt), 32'd4);
    chk("to_err",  32'(err_seen),  32'h2);
    chk("to_done", 32'(done_seen), 32'd0);
    step(4'b1111, 1'b0, 1'b0);
    chk("to_next_sel", 32'(mux_sel), 32'd2);

    // Ack coinciding with the last allowed busy cycle.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    chk("late_ack_done", 32'(done), 32'h2);
    chk("late_ack_err",  32'(err),  32'd0);

    // After requester 1: req bit dropping mid-transaction is ignored.
    step(4'b0011, 1'b0, 1'b0);
    chk("drop_grant0", 32'(grant), 32'h1);
    step(4'b0001, 1'b0, 1'b0);
    chk("drop_hold", 32'(grant), 32'h1);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    chk("drop_next", 32'(grant), 32'h1);
    step(4'b0001, 1'b1, 1'b0);

    // Reset during a transaction owned by requester 3.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0);
    chk("rb_grant", 32'(grant), 32'h8);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b1);
    chk("rb_outs", 32'({grant, mux_sel, mem_req, done, err, busy}), 32'd0);
    step(4'b1001, 1'b0, 1'b0);
    chk("rb_first", 32'(grant), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
